// File: rtl/pe_shearsort.sv
// Shear-sort mesh processing element: holds one {key, payload} word and runs
// snake-order row phases alternated with column phases. Optional NANCI_PE_MODE_EN adds i_desc.
module pe_shearsort #(
    parameter int KEY_WIDTH  = 3,
    parameter int DATA_WIDTH = 3,
    parameter int SQRT_N     = 4,
    parameter int ROW        = 0,
    parameter int COL        = 0,
    parameter int PASSES     = $clog2(SQRT_N) + 1,
    parameter logic [KEY_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
`ifdef NANCI_PE_MODE_EN
    input  logic                             i_desc,
`endif
    input  logic                             i_load_valid,
    input  logic [KEY_WIDTH+DATA_WIDTH-1:0]  i_load,
    input  logic [KEY_WIDTH+DATA_WIDTH-1:0]  i_PE_l,
    input  logic [KEY_WIDTH+DATA_WIDTH-1:0]  i_PE_r,
    input  logic [KEY_WIDTH+DATA_WIDTH-1:0]  i_PE_u,
    input  logic [KEY_WIDTH+DATA_WIDTH-1:0]  i_PE_d,
    output logic [KEY_WIDTH+DATA_WIDTH-1:0]  o_PE,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [1:0]                       o_phase
);

    localparam int W  = KEY_WIDTH + DATA_WIDTH;
    localparam int TW = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [TW-1:0] T_LAST    = TW'(SQRT_N - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    localparam bit COL_ODD   = (COL % 2) != 0;
    localparam bit ROW_ODD   = (ROW % 2) != 0;
    localparam bit AT_LEFT   = (COL == 0);
    localparam bit AT_RIGHT  = (COL == SQRT_N - 1);
    localparam bit AT_TOP    = (ROW == 0);
    localparam bit AT_BOTTOM = (ROW == SQRT_N - 1);

    if (SQRT_N < 2) begin : g_bad_side
        $error("pe_shearsort: SQRT_N must be at least 2");
    end

    // Encoding doubles as the o_phase code.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_COL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] t, t_next;
    logic [PW-1:0] pass_cnt, pass_next;
    logic [W-1:0]  word, word_next;
    logic          desc_mode;

`ifdef NANCI_PE_MODE_EN
    logic desc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desc_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            desc_q <= i_desc;
        end
    end

    assign desc_mode = desc_q;
`else
    assign desc_mode = 1'b0;
`endif

    // NOTE: state is updated only with non-blocking assignments so every PE in
    // the mesh samples its neighbours' pre-edge words in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            t        <= '0;
            pass_cnt <= '0;
            word     <= MAX_INT;
        end else begin
            state    <= state_next;
            t        <= t_next;
            pass_cnt <= pass_next;
            word     <= word_next;
        end
    end

    // NOTE: every combinational output takes a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        t_next     = t;
        pass_next  = pass_cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ROW;
                    t_next     = '0;
                    pass_next  = '0;
                end
            end
            S_ROW: begin
                if (t == T_LAST) begin
                    t_next = '0;
                    if (pass_cnt == PASS_LAST) begin
                        state_next = S_DONE;
                        pass_next  = '0;
                    end else begin
                        state_next = S_COL;
                        pass_next  = pass_cnt + 1'b1;
                    end
                end else begin
                    t_next = t + 1'b1;
                end
            end
            S_COL: begin
                if (t == T_LAST) begin
                    t_next     = '0;
                    state_next = S_ROW;
                end else begin
                    t_next = t + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    logic                 partner_ok;
    logic                 keep_min;
    logic [W-1:0]         partner;
    logic [KEY_WIDTH-1:0] own_key, partner_key;
    logic                 swap;

    // Pairing alternates with step parity; a PE whose partner lies outside the
    // mesh sits that step out.
    always_comb begin
        partner_ok = 1'b0;
        keep_min   = 1'b1;
        partner    = word;
        if (state == S_ROW) begin
            if (!(COL_ODD ^ t[0])) begin
                partner_ok = !AT_RIGHT;
                partner    = i_PE_r;
                keep_min   = !(ROW_ODD ^ desc_mode);
            end else begin
                partner_ok = !AT_LEFT;
                partner    = i_PE_l;
                keep_min   = ROW_ODD ^ desc_mode;
            end
        end else if (state == S_COL) begin
            if (!(ROW_ODD ^ t[0])) begin
                partner_ok = !AT_BOTTOM;
                partner    = i_PE_d;
                keep_min   = !desc_mode;
            end else begin
                partner_ok = !AT_TOP;
                partner    = i_PE_u;
                keep_min   = desc_mode;
            end
        end
    end

    assign own_key     = word[W-1:DATA_WIDTH];
    assign partner_key = partner[W-1:DATA_WIDTH];

    // Strict compares: equal keys never swap, so payloads are never duplicated.
    assign swap = partner_ok &&
                  (keep_min ? (partner_key < own_key) : (partner_key > own_key));

    always_comb begin
        word_next = word;
        if (state == S_IDLE) begin
            if (i_load_valid) begin
                word_next = i_load;
            end
        end else if (state == S_ROW || state == S_COL) begin
            if (swap) begin
                word_next = partner;
            end
        end
    end

    assign o_PE    = word;
    assign o_busy  = (state == S_ROW) || (state == S_COL);
    assign o_done  = (state == S_DONE);
    assign o_phase = state;

endmodule

// File: tb/tb_pe_shearsort.sv
// Directed bench for pe_shearsort: three SQRT_N=2 PEs (row 0 col 0, row 1 col 0,
// row 0 col 1) driven by shared stimulus and checked cycle by cycle.
module tb_pe_shearsort;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       i_load_valid;
    logic [5:0] i_load;
    logic [5:0] i_PE_l, i_PE_r, i_PE_u, i_PE_d;

    logic [5:0] pe_a, pe_b, pe_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [1:0] phase_a, phase_b, phase_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_shearsort #(.KEY_WIDTH(3), .DATA_WIDTH(3), .SQRT_N(2), .ROW(0), .COL(0)) u_a (
        .clk(clk), .rst(rst), .start(start), .i_load_valid(i_load_valid), .i_load(i_load),
        .i_PE_l(i_PE_l), .i_PE_r(i_PE_r), .i_PE_u(i_PE_u), .i_PE_d(i_PE_d),
        .o_PE(pe_a), .o_busy(busy_a), .o_done(done_a), .o_phase(phase_a)
    );

    pe_shearsort #(.KEY_WIDTH(3), .DATA_WIDTH(3), .SQRT_N(2), .ROW(1), .COL(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .i_load_valid(i_load_valid), .i_load(i_load),
        .i_PE_l(i_PE_l), .i_PE_r(i_PE_r), .i_PE_u(i_PE_u), .i_PE_d(i_PE_d),
        .o_PE(pe_b), .o_busy(busy_b), .o_done(done_b), .o_phase(phase_b)
    );

    pe_shearsort #(.KEY_WIDTH(3), .DATA_WIDTH(3), .SQRT_N(2), .ROW(0), .COL(1)) u_c (
        .clk(clk), .rst(rst), .start(start), .i_load_valid(i_load_valid), .i_load(i_load),
        .i_PE_l(i_PE_l), .i_PE_r(i_PE_r), .i_PE_u(i_PE_u), .i_PE_d(i_PE_d),
        .o_PE(pe_c), .o_busy(busy_c), .o_done(done_c), .o_phase(phase_c)
    );

    // Expected state after edges k .. k+6 (start sampled at edge k), with
    // neighbours fixed at l=111_000, r=010_110, u=000_000, d=001_010.
    localparam logic [5:0] EXP_A     [7] = '{6'h29, 6'h16, 6'h16, 6'h0A, 6'h0A, 6'h0A, 6'h0A};
    localparam logic [5:0] EXP_B     [7] = '{6'h29, 6'h29, 6'h29, 6'h29, 6'h29, 6'h29, 6'h29};
    localparam logic [5:0] EXP_C     [7] = '{6'h29, 6'h38, 6'h38, 6'h0A, 6'h0A, 6'h38, 6'h38};
    localparam logic [1:0] EXP_PHASE [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3};
    localparam logic       EXP_BUSY  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic       EXP_DONE  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads 101_001 with start, then checks every cycle of the 6-step sort;
    // a start+load during busy must be ignored.
    task automatic run_full_sort(input string tag);
        i_PE_l       = 6'b111_000;
        i_PE_r       = 6'b010_110;
        i_PE_u       = 6'b000_000;
        i_PE_d       = 6'b001_010;
        i_load       = 6'b101_001;
        i_load_valid = 1'b1;
        start        = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start        = 1'b0;
            i_load_valid = 1'b0;
            if (i == 2) begin
                start        = 1'b1;
                i_load_valid = 1'b1;
                i_load       = 6'b000_111;
            end
            check($sformatf("%s_a_word_%0d", tag, i), 32'(pe_a), 32'(EXP_A[i]));
            check($sformatf("%s_b_word_%0d", tag, i), 32'(pe_b), 32'(EXP_B[i]));
            check($sformatf("%s_c_word_%0d", tag, i), 32'(pe_c), 32'(EXP_C[i]));
            check($sformatf("%s_phase_%0d", tag, i), 32'(phase_a), 32'(EXP_PHASE[i]));
            check($sformatf("%s_busy_%0d", tag, i), 32'(busy_c), 32'(EXP_BUSY[i]));
            check($sformatf("%s_done_%0d", tag, i), 32'(done_a), 32'(EXP_DONE[i]));
        end
        start        = 1'b0;
        i_load_valid = 1'b0;
        step();
        check({tag, "_idle_phase"}, 32'(phase_a), 32'd0);
        check({tag, "_idle_done"},  32'(done_c),  32'd0);
        check({tag, "_idle_busy"},  32'(busy_b),  32'd0);
        check({tag, "_idle_word"},  32'(pe_c),    32'h38);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b1;
        i_load_valid = 1'b1;
        i_load       = 6'b010_101;
        i_PE_l       = 6'h05;
        i_PE_r       = 6'h01;
        i_PE_u       = 6'h02;
        i_PE_d       = 6'h03;

        // Reset holds regardless of start/load activity.
        step();
        step();
        check("rst_word_a", 32'(pe_a),    32'h3F);
        check("rst_word_c", 32'(pe_c),    32'h3F);
        check("rst_busy",   32'(busy_a),  32'd0);
        check("rst_done",   32'(done_a),  32'd0);
        check("rst_phase",  32'(phase_b), 32'd0);

        start        = 1'b0;
        i_load_valid = 1'b0;
        rst          = 1'b1;
        step();
        check("post_rst_word", 32'(pe_b), 32'h3F);

        run_full_sort("sort1");

        // Equal keys: every PE keeps its own word on the first step.
        i_PE_l       = 6'b011_111;
        i_PE_r       = 6'b011_111;
        i_load       = 6'b011_001;
        i_load_valid = 1'b1;
        start        = 1'b1;
        step();
        start        = 1'b0;
        i_load_valid = 1'b0;
        check("tie_loaded", 32'(pe_a), 32'h19);
        step();
        check("tie_a", 32'(pe_a), 32'h19);
        check("tie_b", 32'(pe_b), 32'h19);
        check("tie_c", 32'(pe_c), 32'h19);
        step();
        check("tie_busy_before_rst", 32'(busy_a), 32'd1);

        // Asynchronous reset mid-sort, between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check("midrst_word_a", 32'(pe_a),    32'h3F);
        check("midrst_word_b", 32'(pe_b),    32'h3F);
        check("midrst_busy",   32'(busy_a),  32'd0);
        check("midrst_phase",  32'(phase_c), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("midrst_still_idle", 32'(phase_a), 32'd0);

        run_full_sort("sort2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_shearsort.md
# pe_shearsort

Parametrised mesh processing element for the Nanci sorting fabric. Each instance holds one {key, payload} word and runs a full shear sort in lockstep with its neighbours. The sort alternates odd-even transposition row phases (snake order) with column phases, exchanging words over four neighbour links. Instances tile an SQRT_N × SQRT_N mesh; a global start pulse keeps all PEs cycle-aligned.

## Interface
- KEY_WIDTH, 3, key bits (MSBs of word)
- DATA_WIDTH, 3, payload bits (LSBs of word)
- SQRT_N, 4, mesh side length (≥2)
- ROW, 0, this PE's row index
- COL, 0, this PE's column index
- PASSES, clog2(SQRT_N)+1, number of row phases; column phases = PASSES-1
- MAX_INT, all ones (W bits), reset/padding word; W = KEY_WIDTH+DATA_WIDTH
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin sort (sampled in IDLE)
- i_load_valid  input  1  write i_load into word register (IDLE only)
- i_load  input  W  word to load
- i_PE_l / i_PE_r / i_PE_u / i_PE_d  input  W  neighbours' o_PE
- o_PE  output  W  current word
- o_busy  output  1  sort in progress
- o_done  output  1  one-cycle completion pulse
- o_phase  output  2  0 idle, 1 row, 2 column, 3 done

## Operation
- FSM: IDLE → ROW → (COL → ROW)* → DONE → IDLE. Each ROW/COL phase lasts exactly SQRT_N steps. Step counter t runs 0..SQRT_N-1 and resets at each phase change.
- Pass counter counts row phases; after row phase PASSES → DONE.
- Row step t: partner is right if (COL+t) even, else left. Column step t: partner is down if (ROW+t) even, else up.
- Partner outside mesh (COL=SQRT_N-1 right, COL=0 left, ROW=SQRT_N-1 down, ROW=0 up): hold word.
- Direction: even rows ascending left→right; odd rows descending; columns ascending top→bottom.
- Ascending, partner right/down: keep min. Partner left/up: keep max. Descending row: inverse.
- Compare on key only, unsigned. Equal keys: keep own word (payload preserved, no duplication).
- Load: i_load_valid in IDLE writes o_PE next edge; ignored outside IDLE.
- Load and start together: load applies; first step uses loaded word.
- start outside IDLE ignored.

## Timing
- Reset (async, rst=0): o_PE=MAX_INT, o_busy=0, o_done=0, o_phase=0, counters 0, FSM IDLE.
- Start sampled at edge k → ROW, o_busy=1 after edge k.
- Steps commit at edges k+1 … k+S, where S = SQRT_N·(2·PASSES−1).
- After edge k+S: DONE, o_busy=0, o_done=1, o_phase=3 for one cycle. IDLE after edge k+S+1.
- Each compare-exchange is registered: new word visible one cycle after the step's edge.
- Neighbour inputs are used combinationally in the step they are sampled.
- Reset mid-sort: immediate return to reset values. Partial results are discarded.

## Configuration
- NANCI_PE_MODE_EN defined: adds input i_desc (1 bit), latched on start. i_desc=1 inverts every direction (even rows descending, odd rows ascending, columns descending). Equal keys still hold own word.
- NANCI_PE_MODE_EN undefined: port absent; ascending snake order fixed.

## Test plan
- Reset: rst=0 with any inputs → o_PE=6'b111111, o_busy=0, o_done=0, o_phase=0.
- SQRT_N=2, ROW=0, COL=0. Load 6'b101_001, i_PE_r=6'b010_110, pulse start → after first step o_PE=6'b010_110.
- ROW=1, same stimulus → o_PE stays 6'b101_001 after first step (descending row keeps max).
- Tie, ROW=0, COL=0: own 6'b011_001, i_PE_r=6'b011_111 → o_PE stays 6'b011_001.
- Boundary/latency, SQRT_N=2, PASSES=2, COL=1, ROW=0:
  - Step 1 pairs right (out of mesh) → word held.
  - o_busy high exactly 6 cycles; o_done pulses once on cycle 7.
  - A second start during busy is ignored.
- Mid-sort reset: assert rst=0 at step 3 → o_PE=6'b111111, o_busy=0 the same cycle. A new load+start after release runs the full 6-step sequence.
